// File: rtl/uart_tx_prescaled.sv
// uart_tx_prescaled: UART transmitter (start, LSB-first data, optional parity, stop), prescale+1 clk per bit.
// Rev 1.0
`default_nettype none

module uart_tx_prescaled #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     p_data,
  input  logic                      data_valid,
  input  logic                      par_en,
  input  logic                      par_typ,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tx_out,
  output logic                      busy
);

  localparam int              BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [BIT_W-1:0]          bit_q, bit_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      par_en_q, par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;

  logic                      w_wrap;
  logic                      w_parity;
  logic [BIT_W-1:0]          w_next_bit;

  assign w_wrap     = (cnt_q == presc_q);
  assign w_parity   = par_typ_q ? ~(^data_q) : (^data_q);
  assign w_next_bit = bit_q + 1'b1;

  // tx_d is computed one cycle ahead so the line comes straight from tx_q.
  always_comb begin
    state_d   = state_q;
    cnt_d     = w_wrap ? '0 : cnt_q + 1'b1;
    presc_d   = presc_q;
    bit_d     = bit_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    tx_d      = tx_q;
    busy_d    = busy_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (data_valid) begin
          data_d    = p_data;
          par_en_d  = par_en;
          par_typ_d = par_typ;
          presc_d   = prescale;
          state_d   = S_START;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      S_START: begin
        if (w_wrap) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = data_q[0];
        end
      end
      S_DATA: begin
        if (w_wrap) begin
          if (bit_q == LAST_BIT) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
            tx_d    = par_en_q ? w_parity : 1'b1;
          end else begin
            bit_d = w_next_bit;
            tx_d  = data_q[w_next_bit];
          end
        end
      end
      S_PARITY: begin
        if (w_wrap) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (w_wrap) begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      presc_q   <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_prescaled.sv
// tb_uart_tx_prescaled: directed self-checking bench for uart_tx_prescaled.
// Rev 1.0
`default_nettype none

module tb_uart_tx_prescaled;

  logic       clk;
  logic       rst;
  logic [7:0] pd;
  logic       dv;
  logic       pe;
  logic       pt;
  logic [4:0] ps;
  logic       tx;
  logic       busy;

  int checks = 0;
  int errors = 0;

  uart_tx_prescaled #(
    .DATA_WIDTH     (8),
    .PRESCALE_WIDTH (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (pd),
    .data_valid (dv),
    .par_en     (pe),
    .par_typ    (pt),
    .prescale   (ps),
    .tx_out     (tx),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected line level for bit slot idx of a frame carrying d.
  function automatic logic frame_bit(input logic [7:0] d, input int idx,
                                     input logic e, input logic par);
    if (idx == 0)      return 1'b0;
    else if (idx <= 8) return d[idx-1];
    else if (idx == 9) return e ? par : 1'b1;
    else               return 1'b1;
  endfunction

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_timeout busy=%b expected=0", name, busy);
    end
  endtask

  // One frame, checked cycle by cycle; inputs are scrambled mid-frame.
  task automatic send_frame(input string name, input logic [7:0] d, input int p,
                            input logic e, input logic t, input logic exp_par,
                            input logic [4:0] alt_p);
    int   len, bad, fc;
    logic ftx, fbusy, fexp, ex;
    len = (e ? 11 : 10) * (p + 1);
    bad = 0; fc = -1; ftx = 1'b0; fbusy = 1'b0; fexp = 1'b0;
    @(posedge clk); #1;
    pd = d; pe = e; pt = t; ps = 5'(p); dv = 1'b1;
    @(posedge clk); #1;
    dv = 1'b0;
    for (int c = 0; c < len; c++) begin
      if (c == 3) begin
        pd = ~d; pe = ~e; pt = ~t; ps = alt_p;
      end
      @(negedge clk);
      ex = frame_bit(d, c / (p + 1), e, exp_par);
      if (tx !== ex || busy !== 1'b1) begin
        if (bad == 0) begin
          fc = c; ftx = tx; fbusy = busy; fexp = ex;
        end
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s waveform bad_cycles=%0d first_cycle=%0d tx=%b busy=%b expected tx=%b busy=1",
               name, bad, fc, ftx, fbusy, fexp);
    end
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s frame_end tx=%b busy=%b expected tx=1 busy=0", name, tx, busy);
    end
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b0; dv = 1'b1; pd = 8'hA5; pe = 1'b0; pt = 1'b0; ps = 5'd7;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_hold bad_cycles=%0d tx=%b busy=%b expected tx=1 busy=0", bad, tx, busy);
    end
    @(posedge clk); #1;
    dv = 1'b0; rst = 1'b1;
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL reset_release bad_cycles=%0d tx=%b busy=%b expected tx=1 busy=0", bad, tx, busy);
    end
  endtask

  task automatic test_reset_midframe();
    int bad;
    @(posedge clk); #1;
    pd = 8'hC3; ps = 5'd7; pe = 1'b0; pt = 1'b0; dv = 1'b1;
    @(posedge clk); #1;
    dv = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe_busy busy=%b expected=1", busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midframe_async_reset tx=%b busy=%b expected tx=1 busy=0", tx, busy);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midframe_stays_idle bad_cycles=%0d tx=%b busy=%b expected tx=1 busy=0", bad, tx, busy);
    end
  endtask

  task automatic test_basic();
    // 0x35 LSB first: 1,0,1,0,1,1,0,0 ; 80-cycle frame.
    send_frame("basic_35_p7", 8'h35, 7, 1'b0, 1'b0, 1'b0, 5'd7);
    send_frame("basic_00_p7", 8'h00, 7, 1'b0, 1'b0, 1'b0, 5'd3);
  endtask

  task automatic test_parity();
    send_frame("parity_even_07", 8'h07, 15, 1'b1, 1'b0, 1'b1, 5'd15);
    send_frame("parity_odd_07",  8'h07, 15, 1'b1, 1'b1, 1'b0, 5'd15);
    send_frame("parity_even_A5", 8'hA5, 7,  1'b1, 1'b0, 1'b0, 5'd7);
    send_frame("parity_odd_A5",  8'hA5, 7,  1'b1, 1'b1, 1'b1, 5'd7);
  endtask

  task automatic test_minimum();
    send_frame("min_p0_odd_FF",  8'hFF, 0, 1'b1, 1'b1, 1'b1, 5'd31);
    send_frame("min_p0_even_FF", 8'hFF, 0, 1'b1, 1'b0, 1'b0, 5'd0);
    send_frame("min_p0_nopar_5A", 8'h5A, 0, 1'b0, 1'b0, 1'b0, 5'd9);
  endtask

  task automatic test_prescale_change();
    send_frame("presc_7_keep", 8'hC3, 7,  1'b0, 1'b0, 1'b0, 5'd31);
    send_frame("presc_31_next", 8'h3C, 31, 1'b0, 1'b0, 1'b0, 5'd7);
  endtask

  task automatic test_sweep();
    logic [7:0] b;
    logic       e, t;
    logic [7:0] few [6];
    few = '{8'h00, 8'hFF, 8'hA5, 8'h5A, 8'h01, 8'h80};
    for (int m = 0; m < 4; m++) begin
      e = m[1]; t = m[0];
      for (int v = 0; v < 256; v++) begin
        b = 8'(v);
        send_frame("sweep_p0", b, 0, e, t, t ? ~(^b) : (^b), 5'd21);
      end
      for (int v = 0; v < 6; v++) begin
        b = few[v];
        send_frame("sweep_p7", b, 7, e, t, t ? ~(^b) : (^b), 5'd2);
        send_frame("sweep_p15", b, 15, e, t, t ? ~(^b) : (^b), 5'd0);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] cur, nxt, nv;
    logic       ex, eb;
    int         bad, fc;
    wait_idle("b2b_pre");
    @(posedge clk); #1;
    ps = 5'd7; pe = 1'b0; pt = 1'b0; cur = 8'h3C; pd = cur; dv = 1'b1;
    nxt = 8'h00;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      bad = 0; fc = -1;
      for (int c = 0; c <= 80; c++) begin
        #1;
        nv = 8'(c * 7 + k * 53 + 1);
        pd = nv;
        if (c == 80) nxt = nv;
        @(negedge clk);
        ex = (c < 80) ? frame_bit(cur, c / 8, 1'b0, 1'b0) : 1'b1;
        eb = (c < 80);
        if (tx !== ex || busy !== eb) begin
          if (bad == 0) fc = c;
          bad++;
        end
        @(posedge clk);
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL b2b_frame%0d byte=%h bad_cycles=%0d first_cycle=%0d expected clean 80+1 cycle frame",
                 k, cur, bad, fc);
      end
      cur = nxt;
    end
    #1 dv = 1'b0;
    wait_idle("b2b_post");
  endtask

  initial begin
    rst = 1'b0; dv = 1'b0; pd = 8'h00; pe = 1'b0; pt = 1'b0; ps = 5'd7;
    test_reset();
    test_basic();
    test_parity();
    test_minimum();
    test_prescale_change();
    test_back_to_back();
    test_reset_midframe();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_prescaled.md
Name: uart_tx_prescaled

Overview:
- UART transmitter: the transmit-side counterpart of the UART receiver, running in the same fast clock domain.
- Accepts a parallel byte with a valid strobe and serialises it as a frame: start bit, 8 data bits LSB first, optional parity bit, one stop bit.
- Bit period is prescale+1 clk cycles, matching the receiver's oversampling ratio, so TX can loop back directly into RX.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_WIDTH, 5, width of the prescale input.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- p_data  input  DATA_WIDTH  byte to transmit; sampled only on accept.
- data_valid  input  1  request to send p_data; honoured only when busy=0.
- par_en  input  1  1 = parity bit inserted after data.
- par_typ  input  1  0 = even parity, 1 = odd parity.
- prescale  input  PRESCALE_WIDTH  clk cycles per bit minus 1; nominal 7, 15 or 31.
- tx_out  output  1  serial line; idle high.
- busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (rst=0, async):
  - tx_out=1, busy=0, FSM=IDLE, bit and cycle counters cleared.
  - Takes effect immediately, including mid-frame; the partial frame is abandoned.
  - After release, the block waits for a new data_valid.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered.
- Accept:
  - Occurs on a rising edge with state=IDLE and data_valid=1.
  - On that same edge: latch p_data, par_en, par_typ and prescale; state goes to START; tx_out becomes 0; busy becomes 1.
  - data_valid while busy=1 is ignored: no queueing, no error.
- Parity:
  - Computed from the latched byte: even = XOR of data bits; odd = XNOR of data bits.
- Bit timing:
  - Each state holds tx_out constant for exactly latched_prescale+1 cycles, timed by a cycle counter from 0 to latched_prescale.
  - START drives 0.
  - DATA drives data[bit_idx], bit_idx going 0 to 7 (LSB first). bit_idx advances when the cycle counter wraps.
  - After bit 7, go to PARITY if par_en_latched, else STOP.
  - PARITY drives the parity bit.
  - STOP drives 1.
- Frame end:
  - On the edge ending the final STOP cycle: state goes to IDLE and busy goes to 0. tx_out stays 1.
  - Frame length is 10*(P+1) cycles without parity and 11*(P+1) with parity, where P = latched prescale.
- Back-to-back frames:
  - The earliest next accept is the edge after busy falls.
  - The line is therefore high for at least P+2 cycles between frames: the stop bit plus one idle cycle.
- Input changes mid-frame:
  - Changes to p_data, par_en, par_typ or prescale have no effect on the current frame.
- prescale=0 is legal: one cycle per bit. No range check is made on prescale.
- tx_out must be glitch-free: it is driven from a flop, never from combinational decode.

Test Plan:
- Reset dominance:
  - Stimulus: hold rst=0 for 20 cycles with data_valid=1 and p_data=8'hA5.
  - Required: tx_out=1 and busy=0 throughout.
  - Stimulus: assert rst=0 mid-DATA of a frame.
  - Required: tx_out=1 and busy=0 immediately (asynchronous).
- Basic frame, no parity:
  - Stimulus: prescale=7, par_en=0, p_data=8'h35, one-cycle data_valid.
  - Required: tx_out is 0, then 1,0,1,0,1,1,0,0, then 1, each held for exactly 8 cycles; busy is high for exactly 80 cycles.
- Parity frames:
  - Stimulus: prescale=15, par_en=1, p_data=8'h07, par_typ=0.
  - Required: parity bit=1; 176-cycle frame.
  - Stimulus: same with par_typ=1.
  - Required: parity bit=0.
- Exhaustive loopback:
  - Stimulus: connect tx_out to UART_RX_TOP with identical prescale, par_en and par_typ settings. Sweep prescale 7, 15, 31, all four {par_en,par_typ} combinations, and all 256 bytes.
  - Required: RX data_valid pulses once per frame with p_data equal to the sent byte; par_err and stp_err never assert.
- Busy handling:
  - Stimulus: hold data_valid=1 continuously with p_data changing every cycle, prescale=7, par_en=0.
  - Required: each frame carries the byte present on its accept edge; consecutive frames are separated by exactly one extra idle-high cycle (stop bit lasts 9 cycles in total).
  - Stimulus: change prescale from 7 to 31 mid-frame.
  - Required: the current frame keeps 8-cycle bits; the next frame uses 32-cycle bits.
- Minimum prescale:
  - Stimulus: prescale=0, par_en=1, par_typ=1, p_data=8'hFF.
  - Required: 11-cycle frame 0,1,1,1,1,1,1,1,1,1,1 (odd parity bit=1); busy high for 11 cycles.
